// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch FSM state type for the MIPS pipeline
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction + pc4 holding register with load/clear
module fetch_skid_buf import mips_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc4,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc4
);
  always_ff @(posedge clk)
    if (!rst || clear) begin
      q_instr <= NOP_INSTR;
      q_pc4 <= '0;
    end else if (load) begin
      q_instr <= d_instr;
      q_pc4 <= d_pc4;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage PC and imem fetch FSM; FETCH_SKID_EN adds a skid buffer keeping responses that arrive during stalls
module if_fetch_unit import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] Fpc4,
  output logic [31:0] Finstruction,
  output logic        Fvalid,
  output logic        pc_ena_o
);
  fetch_state_t state;
  logic [31:0] pc, pend_pc, tgt, pc4, nxt, hold_instr, hold_pc4;
  logic squash, pend, redir, rsp, dlv_w, dlv_h, present;
  always_comb begin
    tgt = redirect_pc_i & ~32'd3;
    pc4 = pc + 32'd4;
    nxt = redirect_i ? tgt : pc4;
    redir = redirect_i && !stall_i;
    rsp = state == S_WAIT && imem_rvalid_i && !squash;
    dlv_w = rsp && !stall_i;
    dlv_h = state == S_HOLD && !stall_i;
  end
`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
  fetch_skid_buf u_skid (
    .clk(clk),
    .rst(rst),
    .load(rsp && stall_i),
    .clear(dlv_h),
    .d_instr(imem_rdata_i),
    .d_pc4(pc4),
    .q_instr(hold_instr),
    .q_pc4(hold_pc4)
  );
`else
  localparam bit SKID = 1'b0;
  assign hold_instr = NOP_INSTR;
  assign hold_pc4 = '0;
`endif
  always_comb begin
    present = rst && (state == S_HOLD || (rsp && (SKID || !stall_i)));
    Fvalid = present;
    Finstruction = !present ? NOP_INSTR : state == S_HOLD ? hold_instr : imem_rdata_i;
    Fpc4 = !present ? '0 : state == S_HOLD ? hold_pc4 : pc4;
    imem_req_o = rst && (state == S_REQ || dlv_w);
    imem_addr_o = !rst ? '0 : dlv_w ? nxt : pc;
    pc_ena_o = !stall_i;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_REQ;
      pc <= RESET_PC;
      squash <= 1'b0;
      pend <= 1'b0;
      pend_pc <= '0;
    end else
      case (state)
        S_REQ:
          if (imem_ready_i) begin
            state <= S_WAIT;
            if (redir || pend) begin
              pc <= redir ? tgt : pend_pc;
              squash <= 1'b1;
              pend <= 1'b0;
            end
          end else if (redir) begin
            pend <= 1'b1;
            pend_pc <= tgt;
          end
        S_WAIT:
          if (dlv_w) begin
            pc <= nxt;
            state <= imem_ready_i ? S_WAIT : S_REQ;
          end else if (imem_rvalid_i) begin
            squash <= 1'b0;
            if (redir) pc <= tgt;
            state <= rsp && SKID ? S_HOLD : S_REQ;
          end else if (redir) begin
            pc <= tgt;
            squash <= 1'b1;
          end
        S_HOLD:
          if (dlv_h) begin
            pc <= nxt;
            state <= S_REQ;
          end
        default: state <= S_REQ;
      endcase
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed tests of if_fetch_unit against a latency-programmable instruction memory
module tb_if_fetch_unit;
  import mips_pkg::*;
  logic clk = 1'b0, rst = 1'b0, stall_i = 1'b0, redirect_i = 1'b0, ready_en = 1'b1;
  logic [31:0] redirect_pc_i = '0;
  logic imem_req_o, imem_ready_i, imem_rvalid_i, Fvalid, pc_ena_o, busy;
  logic [31:0] imem_addr_o, imem_rdata_i, Fpc4, Finstruction, baddr;
  int lat = 0, cnt, checks = 0, errors = 0;
  if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .Fpc4(Fpc4),
    .Finstruction(Finstruction), .Fvalid(Fvalid), .pc_ena_o(pc_ena_o)
  );
  always #5 clk = ~clk;
  assign imem_ready_i = ready_en;
  always @(posedge clk)
    if (!rst) begin
      busy <= 1'b0;
      imem_rvalid_i <= 1'b0;
      imem_rdata_i <= '0;
      cnt <= 0;
      baddr <= '0;
    end else begin
      imem_rvalid_i <= 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          imem_rvalid_i <= 1'b1;
          imem_rdata_i <= 32'h2400_0000 | baddr;
          busy <= 1'b0;
        end
        cnt <= cnt - 1;
      end
      if (imem_req_o && imem_ready_i) begin
        baddr <= imem_addr_o;
        if (lat == 0) begin
          imem_rvalid_i <= 1'b1;
          imem_rdata_i <= 32'h2400_0000 | imem_addr_o;
        end else begin
          busy <= 1'b1;
          cnt <= lat;
        end
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_en = 1'b1; lat = 0;
    cyc(); cyc();
    rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; ready_en = 1'b1; lat = 0;
    cyc(); cyc(); #1;
    checks++; if ({imem_req_o, imem_addr_o} !== 33'd0) begin errors++; $display("FAIL reset_req: got req=%b addr=%h expected 0/0", imem_req_o, imem_addr_o); end
    checks++; if ({Fvalid, Fpc4, Finstruction} !== {1'b0, 32'd0, NOP_INSTR}) begin errors++; $display("FAIL reset_out: got v=%b pc4=%h ins=%h expected 0/0/0", Fvalid, Fpc4, Finstruction); end
  endtask
  task automatic test_fill();
    start(); #1;
    checks++; if ({imem_req_o, imem_addr_o, Fvalid} !== {1'b1, 32'h3000, 1'b0}) begin errors++; $display("FAIL fill_first: got req=%b addr=%h v=%b expected 1/3000/0", imem_req_o, imem_addr_o, Fvalid); end
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      checks++;
      if ({Fvalid, Fpc4, Finstruction, imem_req_o, imem_addr_o} !== {1'b1, 32'h3004 + 32'(4 * i), 32'h2400_3000 + 32'(4 * i), 1'b1, 32'h3004 + 32'(4 * i)}) begin
        errors++; $display("FAIL fill_%0d: got v=%b pc4=%h ins=%h req=%b addr=%h expected pc4=addr=%h", i, Fvalid, Fpc4, Finstruction, imem_req_o, imem_addr_o, 32'h3004 + 32'(4 * i));
      end
    end
  endtask
  task automatic test_stall();
    start(); #1;
    cyc(); #1;
    cyc(); stall_i = 1'b1; #1;
    checks++; if (pc_ena_o !== 1'b0) begin errors++; $display("FAIL stall_pc_ena: got %b expected 0", pc_ena_o); end
`ifdef FETCH_SKID_EN
    checks++; if ({Fvalid, Fpc4} !== {1'b1, 32'h3008}) begin errors++; $display("FAIL skid_capture: got v=%b pc4=%h expected 1/3008", Fvalid, Fpc4); end
    cyc(); #1;
    cyc(); #1;
    checks++; if ({Fvalid, Finstruction, imem_req_o} !== {1'b1, 32'h2400_3004, 1'b0}) begin errors++; $display("FAIL skid_hold: got v=%b ins=%h req=%b expected 1/24003004/0", Fvalid, Finstruction, imem_req_o); end
    cyc(); stall_i = 1'b0; #1;
    checks++; if ({Fvalid, Fpc4, imem_req_o} !== {1'b1, 32'h3008, 1'b0}) begin errors++; $display("FAIL skid_release: got v=%b pc4=%h req=%b expected 1/3008/0", Fvalid, Fpc4, imem_req_o); end
    cyc(); #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3008}) begin errors++; $display("FAIL skid_next: got req=%b addr=%h expected 1/3008", imem_req_o, imem_addr_o); end
`else
    checks++; if (Fvalid !== 1'b0) begin errors++; $display("FAIL stall_drop: got v=%b expected 0", Fvalid); end
    cyc(); #1;
    cyc(); #1;
    cyc(); stall_i = 1'b0; #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3004}) begin errors++; $display("FAIL stall_refetch: got req=%b addr=%h expected 1/3004", imem_req_o, imem_addr_o); end
    cyc(); #1;
    checks++; if ({Fvalid, Fpc4, Finstruction} !== {1'b1, 32'h3008, 32'h2400_3004}) begin errors++; $display("FAIL stall_deliver: got v=%b pc4=%h ins=%h expected 1/3008/24003004", Fvalid, Fpc4, Finstruction); end
`endif
  endtask
  task automatic test_redirect_delivery();
    start(); #1;
    cyc(); #1;
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h3103; #1;
    checks++; if ({Fvalid, Fpc4, Finstruction, imem_req_o, imem_addr_o} !== {1'b1, 32'h3008, 32'h2400_3004, 1'b1, 32'h3100}) begin errors++; $display("FAIL redir_slot: got v=%b pc4=%h ins=%h req=%b addr=%h expected 1/3008/24003004/1/3100", Fvalid, Fpc4, Finstruction, imem_req_o, imem_addr_o); end
    cyc(); redirect_i = 1'b0; #1;
    checks++; if ({Fvalid, Fpc4, Finstruction} !== {1'b1, 32'h3104, 32'h2400_3100}) begin errors++; $display("FAIL redir_target: got v=%b pc4=%h ins=%h expected 1/3104/24003100", Fvalid, Fpc4, Finstruction); end
  endtask
  task automatic test_redirect_wait();
    start(); #1;
    cyc(); #1;
    cyc(); lat = 1; #1;
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h3200; #1;
    checks++; if ({Fvalid, imem_req_o} !== 2'b00) begin errors++; $display("FAIL rwait_idle: got v=%b req=%b expected 0/0", Fvalid, imem_req_o); end
    cyc(); redirect_i = 1'b0; #1;
    checks++; if (Fvalid !== 1'b0) begin errors++; $display("FAIL rwait_squash: got v=%b expected 0", Fvalid); end
    cyc(); lat = 0; #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3200}) begin errors++; $display("FAIL rwait_req: got req=%b addr=%h expected 1/3200", imem_req_o, imem_addr_o); end
    cyc(); #1;
    checks++; if ({Fvalid, Fpc4, Finstruction} !== {1'b1, 32'h3204, 32'h2400_3200}) begin errors++; $display("FAIL rwait_deliver: got v=%b pc4=%h ins=%h expected 1/3204/24003200", Fvalid, Fpc4, Finstruction); end
  endtask
  task automatic test_ready_low();
    start(); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); ready_en = 1'b0; #1;
    checks++; if ({Fvalid, Fpc4, imem_req_o, imem_addr_o} !== {1'b1, 32'h300C, 1'b1, 32'h300C}) begin errors++; $display("FAIL rdy_deliver: got v=%b pc4=%h req=%b addr=%h expected 1/300c/1/300c", Fvalid, Fpc4, imem_req_o, imem_addr_o); end
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h3300; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h300C}) begin errors++; $display("FAIL rdy_hold_%0d: got req=%b addr=%h expected 1/300c", i, imem_req_o, imem_addr_o); end
      cyc(); redirect_i = 1'b0; ready_en = (i == 2); #1;
    end
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h300C}) begin errors++; $display("FAIL rdy_accept: got req=%b addr=%h expected 1/300c", imem_req_o, imem_addr_o); end
    cyc(); #1;
    checks++; if ({Fvalid, imem_req_o} !== 2'b00) begin errors++; $display("FAIL rdy_squash: got v=%b req=%b expected 0/0", Fvalid, imem_req_o); end
    cyc(); #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3300}) begin errors++; $display("FAIL rdy_target: got req=%b addr=%h expected 1/3300", imem_req_o, imem_addr_o); end
    cyc(); #1;
    checks++; if ({Fvalid, Fpc4} !== {1'b1, 32'h3304}) begin errors++; $display("FAIL rdy_deliver2: got v=%b pc4=%h expected 1/3304", Fvalid, Fpc4); end
  endtask
  task automatic test_reset_mid();
    start(); lat = 2; #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL rmid_first: got req=%b addr=%h expected 1/3000", imem_req_o, imem_addr_o); end
    cyc(); rst = 1'b0; #1;
    checks++; if ({imem_req_o, imem_addr_o, Fvalid, Fpc4, Finstruction} !== 98'd0) begin errors++; $display("FAIL rmid_zero: got req=%b addr=%h v=%b pc4=%h ins=%h expected all 0", imem_req_o, imem_addr_o, Fvalid, Fpc4, Finstruction); end
    cyc(); rst = 1'b1; lat = 0; #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h expected 1/3000", imem_req_o, imem_addr_o); end
    cyc(); #1;
    checks++; if ({Fvalid, Fpc4, Finstruction} !== {1'b1, 32'h3004, 32'h2400_3000}) begin errors++; $display("FAIL rmid_deliver: got v=%b pc4=%h ins=%h expected 1/3004/24003000", Fvalid, Fpc4, Finstruction); end
  endtask
  task automatic test_wrap();
    start(); #1;
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; #1;
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_align: got req=%b addr=%h expected 1/fffffffc", imem_req_o, imem_addr_o); end
    cyc(); redirect_i = 1'b0; #1;
    checks++; if ({Fvalid, Fpc4, Finstruction, imem_addr_o} !== {1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_pc4: got v=%b pc4=%h ins=%h addr=%h expected 1/0/fffffffc/0", Fvalid, Fpc4, Finstruction, imem_addr_o); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_redirect_delivery();
    test_redirect_wait();
    test_ready_low();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
